// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared types and constants for the instruction-memory responder
package imem_responder_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam int INSN_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x 32 storage, one synchronous read port (with clear) and one write port
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_idx,
    input  logic [INSN_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_rd_clr,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [INSN_W-1:0] o_rd_data
);

    logic [INSN_W-1:0] r_mem [DEPTH];
    logic [INSN_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read register returns the pre-write word when a write hits the same index on the same edge.
    always_ff @(posedge clk) begin
        if (i_rd_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with flush and preload port
// Optional fault check (misaligned / out-of-range address) enabled by IMEM_FAULT_CHECK_EN.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [INSN_W-1:0] rsp_data,
    output logic [XLEN-1:0]   rsp_addr,
    output logic              rsp_fault,
    input  logic              wr_en,
    input  logic [XLEN-1:0]   wr_addr,
    input  logic [INSN_W-1:0] wr_data
);

    localparam int AW = idx_width(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_rsp_addr;
    logic            r_rsp_valid;
    logic            r_rsp_fault;

    logic            w_enter;
    logic            w_fault;
    logic [XLEN-1:0] w_fetch_addr;
    logic            w_unused;

    // With LATENCY=1 the read is issued straight from the incoming address.
    assign w_fetch_addr = (r_state == ST_IDLE) ? req_addr : r_req_addr;

    assign w_enter = ~rst & ~flush &
                     (((r_state == ST_IDLE) & req_valid & (LATENCY == 1)) |
                      ((r_state == ST_WAIT) & (r_cnt == CW'(1))));

`ifdef IMEM_FAULT_CHECK_EN
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(DEPTH * 4);
    assign w_fault = (w_fetch_addr[1:0] != 2'b00) | ({1'b0, w_fetch_addr} >= LIMIT);
`else
    assign w_fault = 1'b0;
`endif

    assign w_unused = ^{w_fetch_addr, wr_addr};

    imem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .clk      (clk),
        .i_wr_en  (wr_en & ~rst),
        .i_wr_idx (wr_addr[AW+1:2]),
        .i_wr_data(wr_data),
        .i_rd_en  (w_enter & ~w_fault),
        .i_rd_clr (rst | (w_enter & w_fault)),
        .i_rd_idx (w_fetch_addr[AW+1:2]),
        .o_rd_data(rsp_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_fault <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_enter) begin
                r_state     <= ST_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= w_fetch_addr;
                r_rsp_fault <= w_fault;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_addr <= req_addr;
                        r_cnt      <= CW'(LATENCY - 1);
                        if (LATENCY != 1) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder (DEPTH=256, LATENCY=2)
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_fault;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    imem_responder #(
        .XLEN   (32),
        .DEPTH  (256),
        .LATENCY(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Presents a request for one edge; the FSM must be idle.
    task automatic issue(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        write_word(32'h0000_0004, 32'hBAD0_BAD0);
        step();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else n_pass++;
        n_checks++; if (rsp_addr !== 32'h0) $display("FAIL reset_rsp_addr got %h want 0", rsp_addr); else n_pass++;
        n_checks++; if (rsp_fault !== 1'b0) $display("FAIL reset_rsp_fault got %b want 0", rsp_fault); else n_pass++;
        rst = 1'b0;
        write_word(32'h0000_0000, 32'h1234_5678);
        write_word(32'h0000_0010, 32'h0050_0093);
        write_word(32'h0000_0020, 32'hDEAD_BEEF);
        write_word(32'h0000_0024, 32'h00A0_0113);
        write_word(32'h0000_0004, 32'h0000_1111);
    endtask

    task automatic test_basic_fetch();
        issue(32'h10);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL basic_ready_t1 got %b want 0", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_valid_t1 got %b want 0", rsp_valid); else n_pass++;
        step();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL basic_valid_t2 got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL basic_ready_t2 got %b want 0", req_ready); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0050_0093) $display("FAIL basic_data got %h want 00500093", rsp_data); else n_pass++;
        n_checks++; if (rsp_addr !== 32'h10) $display("FAIL basic_addr got %h want 00000010", rsp_addr); else n_pass++;
        n_checks++; if (rsp_fault !== 1'b0) $display("FAIL basic_fault got %b want 0", rsp_fault); else n_pass++;
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_addr = 32'h24;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0050_0093 || rsp_addr !== 32'h10 || req_ready !== 1'b0)
                $display("FAIL hold_cycle%0d got v=%b d=%h a=%h r=%b want v=1 d=00500093 a=00000010 r=0",
                         i, rsp_valid, rsp_data, rsp_addr, req_ready);
            else n_pass++;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL release_valid got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL release_ready got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_flush();
        issue(32'h20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL flush_wait_ready got %b want 1", req_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_no_rsp%0d got %b want 0", i, rsp_valid); else n_pass++;
        end
        issue(32'h24);
        step();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL refetch_valid got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 32'h00A0_0113) $display("FAIL refetch_data got %h want 00a00113", rsp_data); else n_pass++;
        n_checks++; if (rsp_addr !== 32'h24) $display("FAIL refetch_addr got %h want 00000024", rsp_addr); else n_pass++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_resp got v=%b r=%b want v=0 r=1", rsp_valid, req_ready); else n_pass++;
    endtask

    task automatic test_flush_idle();
        req_valid = 1'b1; req_addr = 32'h10; flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL flush_idle%0d got v=%b r=%b want v=0 r=1", i, rsp_valid, req_ready); else n_pass++;
        end
        req_valid = 1'b0; flush = 1'b0;
        step();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL flush_idle_after got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue(32'h20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_addr !== 32'h0)
            $display("FAIL rst_wait got r=%b v=%b d=%h a=%h want r=1 v=0 d=0 a=0", req_ready, rsp_valid, rsp_data, rsp_addr);
        else n_pass++;
        step();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_wait_stale got %b want 0", rsp_valid); else n_pass++;
        issue(32'h24);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_addr !== 32'h0 || rsp_fault !== 1'b0)
            $display("FAIL rst_resp got r=%b v=%b d=%h a=%h f=%b want r=1 v=0 d=0 a=0 f=0",
                     req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault);
        else n_pass++;
        issue(32'h10);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0050_0093)
            $display("FAIL rst_keep_mem got v=%b d=%h want v=1 d=00500093", rsp_valid, rsp_data); else n_pass++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Patch the word on the same edge it is read: the old word must come back.
        rsp_ready = 1'b1;
        issue(32'h10);
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h1111_2222;
        step();
        wr_en = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0050_0093)
            $display("FAIL read_old got v=%b d=%h want v=1 d=00500093", rsp_valid, rsp_data); else n_pass++;
        step();
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL b2b_idle got r=%b v=%b want r=1 v=0", req_ready, rsp_valid); else n_pass++;
        issue(32'h10);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1111_2222)
            $display("FAIL patched got v=%b d=%h want v=1 d=11112222", rsp_valid, rsp_data); else n_pass++;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_address_edges();
        rsp_ready = 1'b0;
`ifdef IMEM_FAULT_CHECK_EN
        issue(32'h12);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 32'h0 || rsp_addr !== 32'h12)
            $display("FAIL misalign got v=%b f=%b d=%h a=%h want v=1 f=1 d=0 a=00000012", rsp_valid, rsp_fault, rsp_data, rsp_addr);
        else n_pass++;
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        issue(32'h400);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 32'h0)
            $display("FAIL range got v=%b f=%b d=%h want v=1 f=1 d=0", rsp_valid, rsp_fault, rsp_data); else n_pass++;
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        issue(32'h3FC);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0)
            $display("FAIL last_word got v=%b f=%b want v=1 f=0", rsp_valid, rsp_fault); else n_pass++;
`else
        issue(32'h400);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_data !== 32'h1234_5678 || rsp_addr !== 32'h400)
            $display("FAIL wrap got v=%b f=%b d=%h a=%h want v=1 f=0 d=12345678 a=00000400", rsp_valid, rsp_fault, rsp_data, rsp_addr);
        else n_pass++;
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        issue(32'h13);
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_data !== 32'h1111_2222)
            $display("FAIL low_bits got v=%b f=%b d=%h want v=1 f=0 d=11112222", rsp_valid, rsp_fault, rsp_data);
        else n_pass++;
`endif
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_back_to_back();
        test_address_edges();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
